md_unit: RTL and testbench
==========================

# md_unit

Multi-cycle multiply/divide unit with its own sequencing controller, sitting in the EX stage beside the ALU and immediate extender. It accepts one MULT/MULTU/DIV/DIVU/MTHI/MTLO operation per handshake, counts out a fixed latency, then commits to the architectural HI/LO registers. It exports `busy` so the hazard logic can stall later HI/LO readers or writers. It also accepts a flush so that exceptions can cancel an operation in flight.

## Interface
- `MUL_LAT`, default 5: cycles from accept to HI/LO commit for MULT/MULTU; legal range 1..15.
- `DIV_LAT`, default 10: cycles from accept to HI/LO commit for DIV/DIVU; legal range 1..15.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous assert, active-low.
- `start` input 1: operation valid this cycle.
- `op` input 3: operation code; encodings are held in `md_pkg`.
- `a` input 32: rs operand.
- `b` input 32: rt operand.
- `flush` input 1: cancels any in-flight operation and suppresses `start`.
- `busy` output 1: an operation is pending and HI/LO are not yet final.
- `hi` output 32: architectural HI register.
- `lo` output 32: architectural LO register.

## Operation
- States:
  - IDLE: counter = 0.
  - RUN: counter > 0.
  - `busy` = (state == RUN), registered.
- Accept condition: `start && !busy && !flush`.
  - A `start` that arrives while busy is ignored; the hazard unit guarantees this never happens.
  - The bench asserts that it never happens.
- MULT/MULTU:
  - At accept, compute the 64-bit product (signed or unsigned) into the pending registers.
  - Load the counter with MUL_LAT and go to RUN.
- DIV/DIVU:
  - At accept, compute quotient → pending LO and remainder → pending HI. The quotient truncates toward zero and the remainder takes the sign of the dividend.
  - Load DIV_LAT and go to RUN.
  - If `b` == 0: the operation runs the full DIV_LAT, and HI/LO retain their prior values at commit.
- MTHI/MTLO:
  - Accepted only when idle.
  - Write `a` to HI or LO at the accept edge with no busy period.
- Reserved op codes: accepted as no-ops. No state change and `busy` stays low.
- RUN:
  - The counter decrements every cycle.
  - On the edge where counter goes 1→0, pending values are copied to HI/LO and the unit returns to IDLE.
- `flush`:
  - Any state → IDLE at the next edge.
  - Pending results are discarded and HI/LO are unchanged, including when the flush coincides with the commit edge (flush wins).
- Reset: counter = 0, IDLE, `busy` = 0, `hi` = 0, `lo` = 0, pending registers = 0.
  - Reset mid-operation discards the operation.

## Timing
- Accept at edge E0.
- `busy` is high from just after E0 through edge E0+LAT.
- HI/LO take their new values at edge E0+LAT, which is the same edge on which `busy` falls.
- A new `start` can be accepted at edge E0+LAT+1 at the earliest, so back-to-back throughput is one operation per LAT+1 cycles.
- MTHI/MTLO: the value is visible on `hi`/`lo` in the cycle after the accept edge.
- `hi`/`lo` never change while `busy` is high. Readers stall on `busy` only.

## Configuration
- `MD_UNIT_MADD_EN`: when defined, `op` additionally decodes MADD, MADDU, MSUB and MSUBU.
  - Each computes {HI,LO} ± product, where the accumulator value is sampled at accept.
  - Latency is MUL_LAT and commit rules are identical to MULT.
- When the macro is undefined, those encodings are reserved no-ops.

## Structure
- `md_pkg` holds:
  - the `op` encodings (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO, and the MADD group);
  - the latency defaults;
  - the 4-bit counter width.
- One sub-module, `md_calc`: combinational product/quotient/remainder from `op`, `a`, `b` (and the accumulator when `MD_UNIT_MADD_EN` is defined).
- The controller, counter and HI/LO registers stay in `md_unit`.

## Test plan
- MULT with a=0xFFFFFFFF, b=2:
  - `busy` is high for 5 cycles.
  - Then HI=0xFFFFFFFF, LO=0xFFFFFFFE.
- MULTU with the same operands:
  - HI=0x00000001, LO=0xFFFFFFFE, committed at E0+5.
- DIV with a=0xFFFFFFF9 (-7), b=2:
  - After 10 cycles, LO=0xFFFFFFFD and HI=0xFFFFFFFF.
- DIVU with a=7, b=0, starting from HI=0x11, LO=0x22:
  - `busy` is high for 10 cycles.
  - HI/LO remain 0x11/0x22.
- MULT accepted, then `flush` on the commit edge:
  - HI/LO are unchanged and `busy` is 0 next cycle.
  - A `start` asserted together with `flush` is ignored.
- Async reset:
  - `rst_n` low mid-DIV drops `busy` immediately with HI=LO=0.
  - After release, MTLO with a=0x1234 gives LO=0x1234 on the next cycle.

Source files
------------

// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, latency
// defaults, counter width and the HI/LO result payload.
package md_pkg;

  localparam int unsigned MD_DATA_W      = 32;
  localparam int unsigned MD_OP_W        = 3;
  localparam int unsigned MD_CNT_W       = 4;
  localparam int unsigned MD_MUL_LAT_DEF = 5;
  localparam int unsigned MD_DIV_LAT_DEF = 10;

  localparam logic [MD_OP_W-1:0] MD_MULT  = MD_OP_W'(0);
  localparam logic [MD_OP_W-1:0] MD_MULTU = MD_OP_W'(1);
  localparam logic [MD_OP_W-1:0] MD_DIV   = MD_OP_W'(2);
  localparam logic [MD_OP_W-1:0] MD_DIVU  = MD_OP_W'(3);
  localparam logic [MD_OP_W-1:0] MD_MTHI  = MD_OP_W'(4);
  localparam logic [MD_OP_W-1:0] MD_MTLO  = MD_OP_W'(5);
  // Only two codes remain in a 3-bit op: signed accumulate/subtract use them,
  // the unsigned variants alias onto the same codes.
  localparam logic [MD_OP_W-1:0] MD_MADD  = MD_OP_W'(6);
  localparam logic [MD_OP_W-1:0] MD_MSUB  = MD_OP_W'(7);
  localparam logic [MD_OP_W-1:0] MD_MADDU = MD_OP_W'(6);
  localparam logic [MD_OP_W-1:0] MD_MSUBU = MD_OP_W'(7);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  typedef struct packed {
    logic [MD_DATA_W-1:0] hi;
    logic [MD_DATA_W-1:0] lo;
  } md_res_t;

endpackage

// File: rtl/md_calc.sv
// Combinational product / quotient / remainder for md_unit. MADD/MSUB decode
// is present only when MD_UNIT_MADD_EN is defined.
module md_calc
  import md_pkg::*;
(
  input  logic [MD_OP_W-1:0]   op_i,
  input  logic [MD_DATA_W-1:0] a_i,
  input  logic [MD_DATA_W-1:0] b_i,
  input  md_res_t              acc_i,
  output md_res_t              res_c
);

  logic signed [63:0]          sa64, sb64, prod_s;
  logic        [63:0]          ua64, ub64, prod_u;
  logic signed [MD_DATA_W-1:0] sa, sdiv, q_s, r_s;
  logic        [MD_DATA_W-1:0] udiv, q_u, r_u;
  logic                        b_zero;

  assign sa64   = {{32{a_i[31]}}, a_i};
  assign sb64   = {{32{b_i[31]}}, b_i};
  assign ua64   = {32'h0, a_i};
  assign ub64   = {32'h0, b_i};
  assign prod_s = sa64 * sb64;
  assign prod_u = ua64 * ub64;

  // A zero divisor is replaced by 1 so the dividers never see it; the result
  // is discarded in favour of the accumulator below.
  assign b_zero = (b_i == '0);
  assign sa     = a_i;
  assign sdiv   = b_zero ? MD_DATA_W'(1) : b_i;
  assign udiv   = b_zero ? MD_DATA_W'(1) : b_i;
  assign q_s    = sa / sdiv;
  assign r_s    = sa % sdiv;
  assign q_u    = a_i / udiv;
  assign r_u    = a_i % udiv;

  always_comb begin
    res_c = acc_i;
    case (op_i)
      MD_MULT:  res_c = md_res_t'(prod_s);
      MD_MULTU: res_c = md_res_t'(prod_u);
      MD_DIV: begin
        if (!b_zero) begin
          res_c.hi = r_s;
          res_c.lo = q_s;
        end
      end
      MD_DIVU: begin
        if (!b_zero) begin
          res_c.hi = r_u;
          res_c.lo = q_u;
        end
      end
`ifdef MD_UNIT_MADD_EN
      MD_MADD:  res_c = md_res_t'(64'(acc_i) + 64'(prod_s));
      MD_MSUB:  res_c = md_res_t'(64'(acc_i) - 64'(prod_s));
`endif
      default:  res_c = acc_i;
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit: fixed-latency sequencer, pending result
// registers and architectural HI/LO. Optional MADD group via MD_UNIT_MADD_EN.
module md_unit
  import md_pkg::*;
#(
  parameter int unsigned MUL_LAT = MD_MUL_LAT_DEF,
  parameter int unsigned DIV_LAT = MD_DIV_LAT_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [MD_OP_W-1:0]   op,
  input  logic [MD_DATA_W-1:0] a,
  input  logic [MD_DATA_W-1:0] b,
  input  logic                 flush,
  output logic                 busy,
  output logic [MD_DATA_W-1:0] hi,
  output logic [MD_DATA_W-1:0] lo
);

  md_state_e             state_q, state_d;
  logic [MD_CNT_W-1:0]   cnt_q, cnt_d;
  logic [MD_DATA_W-1:0]  hi_q, hi_d, lo_q, lo_d;
  md_res_t               pend_q, pend_d;
  md_res_t               calc_res;
  md_res_t               acc;

  assign acc = '{hi: hi_q, lo: lo_q};

  md_calc u_calc (
    .op_i  (op),
    .a_i   (a),
    .b_i   (b),
    .acc_i (acc),
    .res_c (calc_res)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      pend_q  <= pend_d;
    end
  end

  // Accept only in IDLE; flush overrides everything, including the commit edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    pend_d  = pend_q;
    if (flush) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            case (op)
`ifdef MD_UNIT_MADD_EN
              MD_MULT, MD_MULTU, MD_MADD, MD_MSUB: begin
`else
              MD_MULT, MD_MULTU: begin
`endif
                pend_d  = calc_res;
                cnt_d   = MD_CNT_W'(MUL_LAT);
                state_d = ST_RUN;
              end
              MD_DIV, MD_DIVU: begin
                pend_d  = calc_res;
                cnt_d   = MD_CNT_W'(DIV_LAT);
                state_d = ST_RUN;
              end
              MD_MTHI: hi_d = a;
              MD_MTLO: lo_d = a;
              default: ;
            endcase
          end
        end
        ST_RUN: begin
          cnt_d = cnt_q - MD_CNT_W'(1);
          if (cnt_q == MD_CNT_W'(1)) begin
            hi_d    = pend_q.hi;
            lo_d    = pend_q.lo;
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign busy = (state_q == ST_RUN);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit with default latencies (MUL 5, DIV 10).
module tb_md_unit;
  import md_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        flush;
  logic        busy;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;

  md_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .flush (flush),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  // The hazard logic must never present a start while the unit is busy.
  always @(posedge clk) begin
    if (rst_n === 1'b1 && start === 1'b1 && busy === 1'b1) begin
      errors++;
      $display("FAIL start_while_busy: start=1 busy=1 at %0t, required busy=0", $time);
    end
  end

  // Called at a negedge; pulses start across one rising edge.
  task automatic drive_op(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv);
    start = 1'b1; op = o; a = av; b = bv;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h want 00000000", hi); end
    checks++; if (lo !== 32'h0) begin errors++; $display("FAIL reset_lo: got %h want 00000000", lo); end
  endtask

  task automatic test_mult();
    int n = 0; bit moved = 0;
    drive_op(MD_MULT, 32'hFFFF_FFFF, 32'd2);
    while (busy === 1'b1 && n < 40) begin
      if (hi !== 32'h0 || lo !== 32'h0) moved = 1;
      @(negedge clk); n++;
    end
    checks++; if (n != 5) begin errors++; $display("FAIL mult_busy_cycles: got %0d want 5", n); end
    checks++; if (moved) begin errors++; $display("FAIL mult_hilo_stable: got changed want stable"); end
    checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi: got %h want ffffffff", hi); end
    checks++; if (lo !== 32'hFFFF_FFFE) begin errors++; $display("FAIL mult_lo: got %h want fffffffe", lo); end
  endtask

  task automatic test_multu();
    int n = 0;
    drive_op(MD_MULTU, 32'hFFFF_FFFF, 32'd2);
    while (busy === 1'b1 && n < 40) begin @(negedge clk); n++; end
    checks++; if (n != 5) begin errors++; $display("FAIL multu_busy_cycles: got %0d want 5", n); end
    checks++; if (hi !== 32'h0000_0001) begin errors++; $display("FAIL multu_hi: got %h want 00000001", hi); end
    checks++; if (lo !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_lo: got %h want fffffffe", lo); end
  endtask

  task automatic test_div();
    int n = 0; bit moved = 0;
    drive_op(MD_DIV, 32'hFFFF_FFF9, 32'd2);
    while (busy === 1'b1 && n < 40) begin
      if (hi !== 32'h0000_0001 || lo !== 32'hFFFF_FFFE) moved = 1;
      @(negedge clk); n++;
    end
    checks++; if (n != 10) begin errors++; $display("FAIL div_busy_cycles: got %0d want 10", n); end
    checks++; if (moved) begin errors++; $display("FAIL div_hilo_stable: got changed want stable"); end
    checks++; if (lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_lo: got %h want fffffffd", lo); end
    checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_hi: got %h want ffffffff", hi); end
  endtask

  task automatic test_mthi_mtlo();
    drive_op(MD_MTHI, 32'h0000_0011, 32'h0);
    checks++; if (hi !== 32'h11) begin errors++; $display("FAIL mthi_hi: got %h want 00000011", hi); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mthi_busy: got %b want 0", busy); end
    drive_op(MD_MTLO, 32'h0000_0022, 32'h0);
    checks++; if (lo !== 32'h22) begin errors++; $display("FAIL mtlo_lo: got %h want 00000022", lo); end
    checks++; if (hi !== 32'h11) begin errors++; $display("FAIL mtlo_hi: got %h want 00000011", hi); end
  endtask

  task automatic test_divu_zero();
    int n = 0;
    drive_op(MD_DIVU, 32'd7, 32'd0);
    while (busy === 1'b1 && n < 40) begin @(negedge clk); n++; end
    checks++; if (n != 10) begin errors++; $display("FAIL divz_busy_cycles: got %0d want 10", n); end
    checks++; if (hi !== 32'h11) begin errors++; $display("FAIL divz_hi: got %h want 00000011", hi); end
    checks++; if (lo !== 32'h22) begin errors++; $display("FAIL divz_lo: got %h want 00000022", lo); end
  endtask

  task automatic test_flush();
    drive_op(MD_MULT, 32'd3, 32'd4);
    repeat (4) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL flush_pre_busy: got %b want 1", busy); end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy: got %b want 0", busy); end
    checks++; if (hi !== 32'h11 || lo !== 32'h22)
      begin errors++; $display("FAIL flush_hilo: got %h/%h want 00000011/00000022", hi, lo); end
    repeat (3) @(negedge clk);
    checks++; if (hi !== 32'h11 || lo !== 32'h22 || busy !== 1'b0)
      begin errors++; $display("FAIL flush_late: got %h/%h busy=%b want 00000011/00000022 busy=0", hi, lo, busy); end
    start = 1'b1; flush = 1'b1; op = MD_MTLO; a = 32'hDEAD_BEEF;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    checks++; if (lo !== 32'h22) begin errors++; $display("FAIL flush_start_lo: got %h want 00000022", lo); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_start_busy: got %b want 0", busy); end
  endtask

`ifndef MD_UNIT_MADD_EN
  task automatic test_reserved();
    drive_op(MD_MADD, 32'h5, 32'h6);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rsvd_busy: got %b want 0", busy); end
    checks++; if (hi !== 32'h11 || lo !== 32'h22)
      begin errors++; $display("FAIL rsvd_hilo: got %h/%h want 00000011/00000022", hi, lo); end
  endtask
`endif

  task automatic test_async_reset();
    drive_op(MD_DIV, 32'd100, 32'd3);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL areset_busy: got %b want 0", busy); end
    checks++; if (hi !== 32'h0 || lo !== 32'h0)
      begin errors++; $display("FAIL areset_hilo: got %h/%h want 00000000/00000000", hi, lo); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    drive_op(MD_MTLO, 32'h0000_1234, 32'h0);
    checks++; if (lo !== 32'h1234) begin errors++; $display("FAIL areset_mtlo: got %h want 00001234", lo); end
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL areset_hi: got %h want 00000000", hi); end
  endtask

  task automatic test_back_to_back();
    int n = 0;
    drive_op(MD_MULT, 32'd3, 32'd4);
    while (busy === 1'b1 && n < 40) begin @(negedge clk); n++; end
    checks++; if (n != 5 || hi !== 32'h0 || lo !== 32'hC)
      begin errors++; $display("FAIL b2b_first: got n=%0d %h/%h want n=5 00000000/0000000c", n, hi, lo); end
    drive_op(MD_DIVU, 32'd100, 32'd7);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept: got busy=%b want 1", busy); end
    n = 0;
    while (busy === 1'b1 && n < 40) begin @(negedge clk); n++; end
    checks++; if (n != 10) begin errors++; $display("FAIL b2b_div_cycles: got %0d want 10", n); end
    checks++; if (hi !== 32'd2 || lo !== 32'd14)
      begin errors++; $display("FAIL b2b_div_hilo: got %h/%h want 00000002/0000000e", hi, lo); end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_mult();
    test_multu();
    test_div();
    test_mthi_mtlo();
    test_divu_zero();
    test_flush();
`ifndef MD_UNIT_MADD_EN
    test_reserved();
`endif
    test_async_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
